// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ
// valid/ready requesters; a grant lasts one packet or MAX_BURST beats.
//
// Ports:
//   trans_clk, trans_rst : write-domain clock, sync active-high reset
//   req_valid/req_last   : per-requester beat valid / last-beat flag
//   req_data             : packed requester data, slice i = requester i
//   req_ready            : per-requester beat accept (only the grantee)
//   fifo_full            : FIFO backpressure
//   write_enable         : FIFO write strobe (combinational accept)
//   trans_data           : FIFO write data (grantee's slice)
//   grant_id             : current or last granted requester
//   busy                 : high while a grant is active
module fifo_write_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int data_bus_length = 8,
  parameter int MAX_BURST       = 4,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int CW  = $clog2(MAX_BURST) + 1
) (
  input  logic                               trans_clk,
  input  logic                               trans_rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic [NUM_REQ*data_bus_length-1:0] req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic                               fifo_full,
  output logic                               write_enable,
  output logic [data_bus_length-1:0]         trans_data,
  output logic [IDW-1:0]                     grant_id,
  output logic                               busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           acc;

  // First valid requester strictly after ptr, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IDW-1:0]     ptr
  );
    logic [IDW-1:0] pick;
    logic           hit;
    int             k;
    pick = '0;
    hit  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!hit && v[IDW'(k)]) begin
        hit  = 1'b1;
        pick = IDW'(k);
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    write_enable = 1'b0;
    acc          = 1'b0;
    trans_data   = req_data[grant_id_q*data_bus_length +: data_bus_length];

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_id_d = rr_pick(req_valid, rr_ptr_q);
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id_q] = !fifo_full;
        acc          = req_valid[grant_id_q] && !fifo_full;
        write_enable = acc;
        if (acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        // Release on packet end, burst cap, or idle grantee. A stall
        // on fifo_full never releases the grant.
        if ((acc && req_last[grant_id_q]) ||
            (acc && beat_cnt_q == CW'(MAX_BURST - 1)) ||
            (!req_valid[grant_id_q] && !fifo_full)) begin
          state_d  = IDLE;
          rr_ptr_d = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset cycle must never hand a beat to the FIFO.
    if (trans_rst) begin
      req_ready    = '0;
      write_enable = 1'b0;
    end
  end

  always_ff @(posedge trans_clk) begin
    if (trans_rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);

endmodule
